// File: rtl/seg_scan_monitor.sv
// Watches a multiplexed 4-digit, 7-segment display bus, rebuilds complete frames and
// infers per-digit blinking and whose turn it is from the blank/non-blank cadence.
module seg_scan_monitor #(
    parameter int BLINK_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sample_en,
    input  logic [6:0] seg,
    input  logic [3:0] anode,
    input  logic       err_clr,
    output logic [6:0] digit0,
    output logic [6:0] digit1,
    output logic [6:0] digit2,
    output logic [6:0] digit3,
    output logic       frame_valid,
    output logic [3:0] blank,
    output logic [3:0] blink,
    output logic       player_turn,
    output logic       turn_valid,
    output logic       seq_err,
    output logic       anode_err,
    output logic [7:0] frame_count
);

    typedef enum logic {
        SYNC = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] TIMEOUT = 4'(BLINK_TIMEOUT);

    state_t     state, state_nxt;
    logic [1:0] exp, exp_nxt;
    logic [6:0] cap [4];

    logic       idx_legal;
    logic       idx_illegal;
    logic [1:0] idx;

    logic       cap_en;
    logic       commit;
    logic       seq_pulse;

    logic [6:0] frame_new [4];
    logic [3:0] blank_new;
    logic       first_commit;
    logic [3:0] prev_blank, prev_blank_nxt;
    logic [3:0] blink_nxt;
    logic [3:0] idle_cnt [4];
    logic [3:0] idle_cnt_nxt [4];
    logic       player_turn_nxt;

    // NOTE: every signal driven in always_comb gets a default first, so no path
    // through the case/if tree can leave it unassigned and infer a latch.
    always_comb begin
        idx_legal   = 1'b1;
        idx_illegal = 1'b0;
        idx         = 2'd0;
        unique case (anode)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            4'b1111: idx_legal = 1'b0;
            default: begin
                idx_legal   = 1'b0;
                idx_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        exp_nxt   = exp;
        cap_en    = 1'b0;
        commit    = 1'b0;
        seq_pulse = 1'b0;
        if (sample_en && idx_legal) begin
            unique case (state)
                SYNC: begin
                    if (idx == 2'd0) begin
                        cap_en    = 1'b1;
                        exp_nxt   = 2'd1;
                        state_nxt = SCAN;
                    end
                end
                SCAN: begin
                    if (idx == exp) begin
                        cap_en = 1'b1;
                        if (idx == 2'd3) begin
                            commit    = 1'b1;
                            exp_nxt   = 2'd0;
                            state_nxt = SYNC;
                        end else begin
                            exp_nxt = exp + 2'd1;
                        end
                    end else begin
                        seq_pulse = 1'b1;
                        if (idx == 2'd0) begin
                            // An early idx0 is taken as the start of a fresh frame.
                            cap_en  = 1'b1;
                            exp_nxt = 2'd1;
                        end else begin
                            exp_nxt   = 2'd0;
                            state_nxt = SYNC;
                        end
                    end
                end
                default: state_nxt = SYNC;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the pre-edge value of every other register regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SYNC;
            exp   <= 2'd0;
            // NOTE: the capture array is small and its reset value is observable
            // behaviour, so it is reset explicitly rather than left unknown.
            for (int i = 0; i < 4; i++) cap[i] <= SEG_OFF;
        end else begin
            state <= state_nxt;
            exp   <= exp_nxt;
            if (cap_en) cap[idx] <= seg;
        end
    end

    // The idx3 value is still on the bus during the committing sample, so it
    // bypasses its capture slot.
    always_comb begin
        for (int d = 0; d < 3; d++) frame_new[d] = cap[d];
        frame_new[3] = seg;
        for (int d = 0; d < 4; d++) blank_new[d] = (frame_new[d] == SEG_OFF);
    end

    always_comb begin
        prev_blank_nxt = prev_blank;
        blink_nxt      = blink;
        for (int d = 0; d < 4; d++) idle_cnt_nxt[d] = idle_cnt[d];
        if (commit) begin
            prev_blank_nxt = blank_new;
            if (!first_commit) begin
                for (int d = 0; d < 4; d++) begin
                    if (blank_new[d] != prev_blank[d]) begin
                        blink_nxt[d]    = 1'b1;
                        idle_cnt_nxt[d] = 4'd0;
                    end else begin
                        if (idle_cnt[d] < TIMEOUT) idle_cnt_nxt[d] = idle_cnt[d] + 4'd1;
                        if (idle_cnt_nxt[d] == TIMEOUT) blink_nxt[d] = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        player_turn_nxt = player_turn;
        if (blink_nxt[0] && !blink_nxt[3]) player_turn_nxt = 1'b1;
        else if (blink_nxt[3] && !blink_nxt[0]) player_turn_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit0       <= SEG_OFF;
            digit1       <= SEG_OFF;
            digit2       <= SEG_OFF;
            digit3       <= SEG_OFF;
            blank        <= 4'b1111;
            frame_valid  <= 1'b0;
            frame_count  <= 8'd0;
            first_commit <= 1'b1;
            prev_blank   <= 4'b0000;
            blink        <= 4'b0000;
            for (int d = 0; d < 4; d++) idle_cnt[d] <= 4'd0;
            player_turn  <= 1'b0;
            turn_valid   <= 1'b0;
            seq_err      <= 1'b0;
            anode_err    <= 1'b0;
        end else begin
            frame_valid <= commit;
            seq_err     <= seq_pulse;
            if (commit) begin
                digit0       <= frame_new[0];
                digit1       <= frame_new[1];
                digit2       <= frame_new[2];
                digit3       <= frame_new[3];
                blank        <= blank_new;
                frame_count  <= frame_count + 8'd1;
                first_commit <= 1'b0;
            end
            prev_blank <= prev_blank_nxt;
            blink      <= blink_nxt;
            for (int d = 0; d < 4; d++) idle_cnt[d] <= idle_cnt_nxt[d];
            player_turn <= player_turn_nxt;
            turn_valid  <= blink_nxt[0] ^ blink_nxt[3];
            if (sample_en && idx_illegal) anode_err <= 1'b1;
            else if (err_clr)             anode_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_scan_monitor.sv
// Self-checking bench for seg_scan_monitor: directed scenarios plus randomized scans,
// all compared against a frame-level reference model.
module tb_seg_scan_monitor;

    localparam int T = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sample_en = 1'b0;
    logic [6:0] seg = 7'h7F;
    logic [3:0] anode = 4'hF;
    logic       err_clr = 1'b0;
    logic [6:0] digit0, digit1, digit2, digit3;
    logic       frame_valid, player_turn, turn_valid, seq_err, anode_err;
    logic [3:0] blank, blink;
    logic [7:0] frame_count;

    int n_checks = 0;
    int n_errors = 0;

    seg_scan_monitor #(.BLINK_TIMEOUT(T)) dut (
        .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .seg(seg),
        .anode(anode), .err_clr(err_clr), .digit0(digit0), .digit1(digit1),
        .digit2(digit2), .digit3(digit3), .frame_valid(frame_valid),
        .blank(blank), .blink(blink), .player_turn(player_turn),
        .turn_valid(turn_valid), .seq_err(seq_err), .anode_err(anode_err),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // Reference model: a frame is a list of captured digits; n = how many so far.
    int         m_n;
    logic [6:0] m_part [4];
    logic [6:0] m_dig [4];
    logic       m_fv, m_seq, m_aerr, m_turn, m_tv, m_first;
    logic [7:0] m_fc;
    logic       m_blink [4];
    logic       m_prevb [4];
    int         m_same [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int decode(input logic [3:0] an);
        case (an)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            4'b1111: return -1;
            default: return -2;
        endcase
    endfunction

    task automatic model_reset();
        m_n = 0; m_fv = 0; m_seq = 0; m_aerr = 0; m_turn = 0; m_tv = 0;
        m_first = 1; m_fc = 0;
        for (int d = 0; d < 4; d++) begin
            m_dig[d] = 7'h7F; m_blink[d] = 0; m_prevb[d] = 0; m_same[d] = 0;
        end
    endtask

    task automatic model_commit();
        m_fv = 1;
        m_fc = m_fc + 8'd1;
        for (int d = 0; d < 4; d++) begin
            logic b;
            m_dig[d] = m_part[d];
            b = (m_part[d] == 7'h7F);
            if (!m_first) begin
                if (b != m_prevb[d]) begin
                    m_blink[d] = 1; m_same[d] = 0;
                end else begin
                    m_same[d] = (m_same[d] + 1 > T) ? T : m_same[d] + 1;
                    if (m_same[d] == T) m_blink[d] = 0;
                end
            end
            m_prevb[d] = b;
        end
        m_first = 0;
        if (m_blink[0] && !m_blink[3]) m_turn = 1;
        else if (m_blink[3] && !m_blink[0]) m_turn = 0;
        m_tv = m_blink[0] ^ m_blink[3];
    endtask

    task automatic model_step(input logic en, input logic [3:0] an, input logic [6:0] sg,
                              input logic clr);
        int k;
        k = decode(an);
        m_fv = 0;
        m_seq = 0;
        if (en && k == -2) m_aerr = 1;
        else if (clr) m_aerr = 0;
        if (en && k >= 0) begin
            if (m_n == 0) begin
                if (k == 0) begin m_part[0] = sg; m_n = 1; end
            end else if (k == m_n) begin
                m_part[k] = sg;
                m_n++;
                if (m_n == 4) begin model_commit(); m_n = 0; end
            end else begin
                m_seq = 1;
                if (k == 0) begin m_part[0] = sg; m_n = 1; end
                else m_n = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] eb, ebl;
        for (int d = 0; d < 4; d++) begin
            eb[d]  = (m_dig[d] == 7'h7F);
            ebl[d] = m_blink[d];
        end
        check("digit0", 32'(digit0), 32'(m_dig[0]));
        check("digit1", 32'(digit1), 32'(m_dig[1]));
        check("digit2", 32'(digit2), 32'(m_dig[2]));
        check("digit3", 32'(digit3), 32'(m_dig[3]));
        check("frame_valid", 32'(frame_valid), 32'(m_fv));
        check("blank", 32'(blank), 32'(eb));
        check("blink", 32'(blink), 32'(ebl));
        check("player_turn", 32'(player_turn), 32'(m_turn));
        check("turn_valid", 32'(turn_valid), 32'(m_tv));
        check("seq_err", 32'(seq_err), 32'(m_seq));
        check("anode_err", 32'(anode_err), 32'(m_aerr));
        check("frame_count", 32'(frame_count), 32'(m_fc));
    endtask

    task automatic cyc(input logic en, input logic [3:0] an, input logic [6:0] sg,
                       input logic clr);
        @(negedge clk);
        sample_en = en; anode = an; seg = sg; err_clr = clr;
        @(posedge clk);
        model_step(en, an, sg, clr);
        #1 compare_all();
    endtask

    task automatic idle();
        cyc(1'b0, 4'hF, 7'h7F, 1'b0);
    endtask

    task automatic send_frame(input logic [6:0] s0, s1, s2, s3);
        cyc(1'b1, 4'b1110, s0, 1'b0);
        cyc(1'b1, 4'b1101, s1, 1'b0);
        cyc(1'b1, 4'b1011, s2, 1'b0);
        cyc(1'b1, 4'b0111, s3, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; sample_en = 1'b0; anode = 4'hF; err_clr = 1'b0;
        #1 model_reset();
        compare_all();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int ptr;
        do_reset();
        check("rst_digit0", 32'(digit0), 32'h7F);
        check("rst_blank", 32'(blank), 32'hF);
        idle();

        // Basic frame
        send_frame(7'h40, 7'h79, 7'h24, 7'h30);
        check("f1_digits", {digit0, digit1, digit2, digit3}, {7'h40, 7'h79, 7'h24, 7'h30});
        check("f1_fv", 32'(frame_valid), 32'h1);
        check("f1_fc", 32'(frame_count), 32'h1);
        check("f1_blank", 32'(blank), 32'h0);
        idle();
        check("f1_fv_drop", 32'(frame_valid), 32'h0);

        // Blink onset then timeout
        do_reset();
        for (int i = 0; i < 10; i++)
            send_frame((i % 2 == 0) ? 7'h7F : 7'h40, 7'h79, 7'h24, 7'h30);
        check("blink_on", 32'(blink), 32'h1);
        check("turn_on", {30'd0, turn_valid, player_turn}, 32'h3);
        for (int i = 0; i < 8; i++) begin
            send_frame(7'h40, 7'h79, 7'h24, 7'h30);
            if (i == 6) check("blink_hold7", 32'(blink), 32'h1);
        end
        check("blink_off8", 32'(blink), 32'h0);
        check("turn_off", 32'(turn_valid), 32'h0);
        check("turn_held", 32'(player_turn), 32'h1);

        // Out-of-order scan
        cyc(1'b1, 4'b1110, 7'h11, 1'b0);
        cyc(1'b1, 4'b1011, 7'h22, 1'b0);
        check("seq_pulse", 32'(seq_err), 32'h1);
        idle();
        check("seq_drop", {30'd0, seq_err, frame_valid}, 32'h0);
        send_frame(7'h06, 7'h5B, 7'h4F, 7'h66);
        check("seq_recover", 32'(frame_valid), 32'h1);

        // Illegal anode and err_clr priority
        cyc(1'b1, 4'b1100, 7'h00, 1'b0);
        check("aerr_set", 32'(anode_err), 32'h1);
        check("aerr_digits", 32'(digit0), 32'h06);
        cyc(1'b0, 4'hF, 7'h7F, 1'b1);
        check("aerr_clr", 32'(anode_err), 32'h0);
        cyc(1'b1, 4'b1100, 7'h00, 1'b1);
        check("aerr_setwins", 32'(anode_err), 32'h1);
        cyc(1'b0, 4'hF, 7'h7F, 1'b1);

        // Reset mid-frame discards partial captures
        do_reset();
        cyc(1'b1, 4'b1110, 7'h40, 1'b0);
        cyc(1'b1, 4'b1101, 7'h79, 1'b0);
        do_reset();
        cyc(1'b1, 4'b1011, 7'h24, 1'b0);
        cyc(1'b1, 4'b0111, 7'h30, 1'b0);
        check("rst_mid_fv", 32'(frame_valid), 32'h0);
        check("rst_mid_dig", 32'(digit3), 32'h7F);

        // Frame counter wrap
        do_reset();
        for (int i = 0; i < 256; i++) send_frame(7'h01, 7'h02, 7'h03, 7'h04);
        check("wrap_fc", 32'(frame_count), 32'h0);
        check("wrap_fv", 32'(frame_valid), 32'h1);

        // Randomized scans
        do_reset();
        ptr = 0;
        for (int i = 0; i < 3000; i++) begin
            logic       en, clr;
            logic [3:0] an;
            logic [6:0] sg;
            int r;
            en = ($urandom_range(0, 99) < 85);
            r = int'($urandom_range(0, 99));
            if (r < 80) an = ~(4'b0001 << ptr);
            else if (r < 88) an = 4'hF;
            else if (r < 94) an = ~(4'b0001 << $urandom_range(0, 3));
            else an = (r % 2 == 0) ? 4'b1100 : 4'b0000;
            if (en && r < 80) ptr = (ptr + 1) % 4;
            case ($urandom_range(0, 3))
                0, 2:    sg = 7'h7F;
                1:       sg = 7'h40;
                default: sg = 7'($urandom_range(0, 127));
            endcase
            clr = ($urandom_range(0, 19) == 0);
            cyc(en, an, sg, clr);
            if (i % 700 == 699) begin
                do_reset();
                ptr = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_monitor.md
SEG_SCAN_MONITOR -- requirements
Module: seg_scan_monitor

Interface
REQ-001 Parameter BLINK_TIMEOUT, default 8: number of consecutive committed frames without a blank/non-blank change after which a digit's blink flag SHALL clear (range 2..15).
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 sample_en  input  1  one-cycle qualifier; seg/anode SHALL be sampled only on cycles with sample_en=1.
REQ-005 seg  input  7  active-low segment bus from the multiplexed display driver.
REQ-006 anode  input  4  active-low digit select from the same driver.
REQ-007 err_clr  input  1  synchronous clear of anode_err.
REQ-008 digit0..digit3  output  7 each  last complete frame's segment pattern per digit.
REQ-009 frame_valid  output  1  one-cycle pulse when digit0..3 update.
REQ-010 blank  output  4  bit d=1 when committed digit d equals 7'b1111111.
REQ-011 blink  output  4  bit d=1 while digit d is alternating blank/non-blank.
REQ-012 player_turn  output  1  inferred turn: 1 = player 1, 0 = player 2.
REQ-013 turn_valid  output  1  player_turn meaningful.
REQ-014 seq_err  output  1  one-cycle pulse on out-of-order scan.
REQ-015 anode_err  output  1  sticky flag for illegal anode pattern.
REQ-016 frame_count  output  8  committed-frame counter, wraps 255->0.

Function
REQ-017 Anode decode on a sampled cycle SHALL be: 1110->idx0, 1101->idx1, 1011->idx2, 0111->idx3, 1111->idle (sample ignored, no state change), any other value->illegal.
REQ-018 An illegal anode SHALL set anode_err, drop the sample, and leave FSM state unchanged; err_clr SHALL clear anode_err unless an illegal sample occurs in the same cycle (set wins).
REQ-019 FSM states SHALL be SYNC and SCAN with a 2-bit expected index exp.
REQ-020 In SYNC: idx0 SHALL capture seg into cap0, set exp=1, and go to SCAN; idx1..3 SHALL be ignored without seq_err.
REQ-021 In SCAN with idx==exp: seg SHALL be captured into cap[idx] and exp incremented; on idx3 the frame SHALL commit and state SHALL return to exp=1 only after a fresh idx0, i.e. go to SYNC.
REQ-022 In SCAN with idx!=exp: seq_err SHALL pulse; if idx==0 the new sample SHALL start a new frame (cap0 captured, exp=1, stay SCAN), otherwise state SHALL go to SYNC and partial captures SHALL be discarded.
REQ-023 Commit: the cycle after the idx3 sample, digit0..3 SHALL load cap0..3 (including the idx3 value just sampled), blank SHALL update, frame_valid SHALL pulse for exactly one cycle, and frame_count SHALL increment.
REQ-024 Blink tracking per digit d at each commit: the first commit after reset SHALL only load prev_blank[d]; afterwards, if new blank[d] != prev_blank[d], blink[d]=1 and idle_cnt[d]=0; otherwise idle_cnt[d] SHALL increment saturating at BLINK_TIMEOUT, and blink[d] SHALL clear on the commit at which idle_cnt[d] reaches BLINK_TIMEOUT.
REQ-025 turn_valid SHALL equal blink[0] XOR blink[3]; player_turn SHALL be 1 when blink[0]=1 and blink[3]=0, 0 when blink[3]=1 and blink[0]=0, and SHALL hold its last value otherwise.
REQ-026 All outputs SHALL be registered; sample-to-frame_valid latency SHALL be 1 clk from the idx3 sample.
REQ-027 sample_en=0 cycles SHALL never change capture or FSM state; a sample_en pulse coinciding with commit SHALL be processed normally.

Reset
REQ-028 While reset_n=0: state=SYNC, exp=0, digit0..3=7'b1111111, cap0..3=7'b1111111, blank=4'b1111, blink=0, prev_blank=0, idle_cnt=0, player_turn=0, turn_valid=0, frame_valid=0, seq_err=0, anode_err=0, frame_count=0, first-commit flag set.
REQ-029 Reset asserted mid-frame SHALL discard partial captures; no frame_valid SHALL follow deassertion until a full idx0..idx3 sequence is sampled.

Verification
REQ-030 Scan 1110/0x40, 1101/0x79, 1011/0x24, 0111/0x30 -> one cycle later digit0..3=0x40,0x79,0x24,0x30, frame_valid one pulse, frame_count=1, blank=0.
REQ-031 Ten frames with digit0 alternating 0x7F/0x40, digit3 constant 0x30 -> blink=4'b0001, turn_valid=1, player_turn=1; then 8 frames digit0 constant -> blink[0]=0 on the 8th, turn_valid=0.
REQ-032 Sequence idx0, idx2 -> seq_err pulse, state SYNC, no frame_valid; following idx0..3 -> normal commit.
REQ-033 anode=4'b1100 sampled -> anode_err=1, digits unchanged; err_clr pulse -> anode_err=0; err_clr with simultaneous illegal sample -> anode_err stays 1.
REQ-034 reset_n low after idx0,idx1 captured, then released, then idx2,idx3 -> no commit, digits remain 0x7F.
REQ-035 256 full frames -> frame_count wraps to 0 with frame_valid pulsing on the 256th commit.
